uart_sram_tx_interface: RTL and testbench
=========================================

Name: uart_sram_tx_interface

Overview:
- Reads a block of 16-bit words from SRAM and streams them out on the UART transmit pin, high byte first.
- Format is 8N1, LSB first, 115200 baud from the 50 MHz clock.
- Opposite direction of the existing UART-receive-to-SRAM path; it will replace the constant-high tie-off on UART_TX_O.
- The top-level arbiter gives it the SRAM port while Busy is high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50e6/115200, rounded); benches use 4.
- SRAM_RD_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid; fixed by the SRAM controller.

Ports:
- CLOCK_50_I  in  1  50 MHz clock
- resetn  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; begins a transfer when idle
- Start_address  in  18  first SRAM word address, sampled with Start
- Word_count  in  18  number of words to send, sampled with Start
- SRAM_address  out  18  SRAM read address
- SRAM_we_n  out  1  constant 1 (read only)
- SRAM_read_data  in  16  SRAM read data
- UART_TX_O  out  1  serial line, idles high
- Busy  out  1  high while a transfer is in progress
- Done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset values: SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0. Reset mid-frame forces UART_TX_O high immediately (asynchronous) and returns to idle. No partial frame resumes.
- Frame format: start bit 0, data[0..7], stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
- Serializer handshake: Tx_ready is high when the serializer is idle and also in the last cycle of a stop bit. A Tx_load in a cycle where Tx_ready is high latches Tx_data, and the start bit begins the next cycle. Tx_load while Tx_ready is low is illegal; the controller never issues it.
- Controller FSM states: S_TX_IDLE, S_TX_RD_W1, S_TX_RD_W2, S_TX_LATCH, S_TX_SEND_HI, S_TX_SEND_LO, S_TX_FINISH.
- S_TX_IDLE:
  - Start with Word_count≠0: register SRAM_address=Start_address, set Busy=1, go to S_TX_RD_W1.
  - Start with Word_count=0: Done pulses the next cycle, Busy stays 0, no SRAM read, line stays high.
- S_TX_RD_W1 → S_TX_RD_W2 → S_TX_LATCH. In S_TX_LATCH, capture SRAM_read_data into word_buf (two cycles after the address) and assert Tx_load with word_buf[15:8].
  - Latency: Start sampled at edge k; UART_TX_O falls after edge k+4.
- S_TX_SEND_HI: wait for Tx_ready, then load word_buf[7:0] and go to S_TX_SEND_LO. At this point, if words remain, drive SRAM_address+1 to prefetch.
- S_TX_SEND_LO:
  - Prefetched data arrives two cycles after the prefetch address; capture it into next_buf.
  - On Tx_ready with words remaining: word_buf←next_buf, load word_buf[15:8], go to S_TX_SEND_HI.
  - On Tx_ready with none remaining: go to S_TX_FINISH.
  - Result: frames are back-to-back with no idle bit between them, including across word boundaries.
- S_TX_FINISH: wait until the last stop bit fully completes (serializer idle). Pulse Done and drop Busy in the same cycle, then return to S_TX_IDLE.
- Address arithmetic is 18-bit and wraps from 18'h3FFFF to 18'h00000. The words-remaining counter is 18 bits and decrements once per word latched.
- Start while Busy is ignored, and Start_address/Word_count are not resampled.
- SRAM_address holds its last value when idle; the top-level mux selects the VGA address then.

Decomposition:
- Shared package (alongside the existing state definitions): tx_state_type enum for the FSM states above, plus constants UART_FRAME_BITS=10 and default CLKS_PER_BIT=434.
- One sub-module, uart_tx_byte:
  - Inputs: CLOCK_50_I, resetn, Tx_load, Tx_data[7:0]. Outputs: Tx_ready, UART_TX_O.
  - Internals: baud counter, bit index 0–9, shift register.
- The parent holds the SRAM-read FSM, word_buf, next_buf, address counter and word counter.

Test Plan:
- After reset, with no Start for 1000 cycles → UART_TX_O=1, Busy=0, Done=0, SRAM_we_n=1.
- CLKS_PER_BIT=4, SRAM[0x00010]=0xA55A, Start_address=0x00010, Word_count=1 → line falls 4 cycles after Start; bytes 0xA5 then 0x5A, each bit 4 cycles; exactly 80 cycles of framing with no gap; Done pulses once; Busy falls with it.
- SRAM[0x3FFFF]=0x1234, SRAM[0x00000]=0xBEEF, Word_count=2 → addresses 0x3FFFF then 0x00000 driven; decoded bytes 12,34,BE,EF; 4 frames contiguous (160 cycles at CLKS_PER_BIT=4).
- Word_count=0 → Done pulses the cycle after Start; UART_TX_O never leaves 1; Busy stays 0.
- Second Start pulse mid-transfer with different address/count → ignored; the original byte stream completes unchanged.
- resetn asserted during the data bits of the second byte → UART_TX_O=1 within the same cycle, Busy=0; a fresh Start afterwards sends the complete correct stream.

Source files
------------

// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared definitions for the SRAM-to-UART transmit path.
//   tx_state_type         : controller FSM states
//   UART_FRAME_BITS       : start + 8 data + stop
//   DEFAULT_CLKS_PER_BIT  : 50 MHz / 115200 baud, rounded
//   DEFAULT_SRAM_RD_LATENCY : address-to-data cycles of the SRAM controller
package uart_sram_tx_interface_pkg;

  localparam int UART_FRAME_BITS         = 10;
  localparam int DEFAULT_CLKS_PER_BIT    = 434;
  localparam int DEFAULT_SRAM_RD_LATENCY = 2;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_RD_W1,
    S_TX_RD_W2,
    S_TX_LATCH,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_FINISH
  } tx_state_type;

endpackage

// File: rtl/uart_sram_tx_interface_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, LSB first.
//   CLOCK_50_I, resetn : clock, asynchronous active-low reset
//   Tx_load, Tx_data   : load request and byte; accepted only while Tx_ready
//   Tx_ready           : idle, or in the last cycle of the stop bit
//   UART_TX_O          : serial line, high when idle or in reset
module uart_tx_byte
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       Tx_load,
  input  logic [7:0] Tx_data,
  output logic       Tx_ready,
  output logic       UART_TX_O
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic                       active;
  logic [CNT_W-1:0]           baud_cnt;
  logic [3:0]                 bit_idx;
  logic [UART_FRAME_BITS-1:0] shift_reg;
  logic                       bit_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  // Ready in the final stop-bit cycle lets the next frame start with no idle gap.
  assign Tx_ready = !active || (bit_end && (bit_idx == BIT_LAST));
  // Driven from async-reset flops, so reset forces the line high at once.
  assign UART_TX_O = active ? shift_reg[0] : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '1;
    end else if (Tx_load && Tx_ready) begin
      active    <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= {1'b1, Tx_data, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == BIT_LAST) begin
          active <= 1'b0;
        end else begin
          bit_idx   <= bit_idx + 4'd1;
          shift_reg <= {1'b1, shift_reg[UART_FRAME_BITS-1:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// uart_sram_tx_interface: reads Word_count 16-bit words from SRAM starting
// at Start_address and sends each as two UART frames, high byte first.
//   CLOCK_50_I, resetn   : clock, asynchronous active-low reset
//   Start                : one-cycle pulse, accepted only when idle
//   Start_address        : first word address (18 bit, wraps)
//   Word_count           : number of words; zero just pulses Done
//   SRAM_address         : read address, holds its last value when idle
//   SRAM_we_n            : always 1 (read only)
//   SRAM_read_data       : read data, valid SRAM_RD_LATENCY cycles after address
//   UART_TX_O            : serial line
//   Busy                 : high while this block owns the SRAM port
//   Done                 : one-cycle pulse at end of transfer
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
  parameter int SRAM_RD_LATENCY = DEFAULT_SRAM_RD_LATENCY
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  tx_state_type state, next_state;

  logic [17:0]              words_left;
  logic [15:0]              word_buf;
  logic [15:0]              next_buf;
  logic                     hi_load_q;   // first word: load high byte the cycle after capture
  logic [SRAM_RD_LATENCY:0] rd_pipe;     // tracks the prefetch read in flight
  logic                     words_remain;

  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       prefetch;
  logic       advance_word;
  logic       accept_start;

  assign SRAM_we_n    = 1'b1;
  assign words_remain = (words_left != 18'd0);
  assign accept_start = (state == S_TX_IDLE) && Start;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .CLOCK_50_I(CLOCK_50_I),
    .resetn    (resetn),
    .Tx_load   (tx_load),
    .Tx_data   (tx_data),
    .Tx_ready  (tx_ready),
    .UART_TX_O (UART_TX_O)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_TX_IDLE;
    else         state <= next_state;
  end

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_TX_IDLE:    if (Start && (Word_count != 18'd0)) next_state = S_TX_RD_W1;
      S_TX_RD_W1:   next_state = S_TX_RD_W2;
      S_TX_RD_W2:   next_state = S_TX_LATCH;
      S_TX_LATCH:   next_state = S_TX_SEND_HI;
      S_TX_SEND_HI: if (!hi_load_q && tx_ready) next_state = S_TX_SEND_LO;
      S_TX_SEND_LO: if (tx_ready) next_state = words_remain ? S_TX_SEND_HI : S_TX_FINISH;
      S_TX_FINISH:  if (tx_ready) next_state = S_TX_IDLE;
      default:      next_state = S_TX_IDLE;
    endcase
  end

  always_comb begin
    tx_load      = 1'b0;
    tx_data      = word_buf[15:8];
    prefetch     = 1'b0;
    advance_word = 1'b0;
    Busy         = (state != S_TX_IDLE);
    case (state)
      S_TX_SEND_HI: begin
        if (hi_load_q) begin
          tx_load = 1'b1;
        end else if (tx_ready) begin
          tx_load  = 1'b1;
          tx_data  = word_buf[7:0];
          prefetch = words_remain;
        end
      end
      S_TX_SEND_LO: begin
        // Hand the prefetched high byte over in the same cycle so the
        // next word follows the previous stop bit directly.
        if (tx_ready && words_remain) begin
          tx_load      = 1'b1;
          tx_data      = next_buf[15:8];
          advance_word = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      SRAM_address <= '0;
      words_left   <= '0;
      word_buf     <= '0;
      next_buf     <= '0;
      hi_load_q    <= 1'b0;
      rd_pipe      <= '0;
      Done         <= 1'b0;
    end else begin
      Done      <= (accept_start && (Word_count == 18'd0)) ||
                   ((state == S_TX_FINISH) && tx_ready);
      hi_load_q <= (state == S_TX_LATCH);
      rd_pipe   <= {rd_pipe[SRAM_RD_LATENCY-1:0], prefetch};

      if (accept_start && (Word_count != 18'd0)) begin
        SRAM_address <= Start_address;
        words_left   <= Word_count;
      end
      if (state == S_TX_LATCH) begin
        word_buf   <= SRAM_read_data;
        words_left <= words_left - 18'd1;
      end
      if (prefetch) SRAM_address <= SRAM_address + 18'd1;
      if (rd_pipe[SRAM_RD_LATENCY]) next_buf <= SRAM_read_data;
      if (advance_word) begin
        word_buf   <= next_buf;
        words_left <= words_left - 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Directed bench for uart_sram_tx_interface at CLKS_PER_BIT=4.
module tb_uart_sram_tx_interface;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int LOG_N = 4096;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        Start;
  logic [17:0] Start_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic        line_log [LOG_N];
  logic        done_log [LOG_N];
  logic        busy_log [LOG_N];
  logic [17:0] addr_log [LOG_N];

  logic [15:0] rd_p1;

  uart_sram_tx_interface #(
    .CLKS_PER_BIT   (CPB),
    .SRAM_RD_LATENCY(2)
  ) dut (
    .CLOCK_50_I    (CLOCK_50_I),
    .resetn        (resetn),
    .Start         (Start),
    .Start_address (Start_address),
    .Word_count    (Word_count),
    .SRAM_address  (SRAM_address),
    .SRAM_we_n     (SRAM_we_n),
    .SRAM_read_data(SRAM_read_data),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  function automatic logic [15:0] sram_word(input logic [17:0] a);
    case (a)
      18'h00010: return 16'hA55A;
      18'h3FFFF: return 16'h1234;
      18'h00000: return 16'hBEEF;
      default:   return 16'hC3C3;
    endcase
  endfunction

  // Two-stage SRAM read model: data valid two cycles after the address.
  always @(posedge CLOCK_50_I) begin
    rd_p1          <= sram_word(SRAM_address);
    SRAM_read_data <= rd_p1;
  end

  always @(posedge CLOCK_50_I) cyc <= cyc + 1;

  // Index i holds the values in the cycle following clock edge i.
  always @(negedge CLOCK_50_I) begin
    if (cyc < LOG_N) begin
      line_log[cyc] = UART_TX_O;
      done_log[cyc] = Done;
      busy_log[cyc] = Busy;
      addr_log[cyc] = SRAM_address;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLOCK_50_I);
  endtask

  // Pulse Start for one cycle; k is the edge that samples it.
  task automatic start_xfer(input logic [17:0] a, input logic [17:0] n, output int k);
    @(negedge CLOCK_50_I);
    Start = 1'b1; Start_address = a; Word_count = n;
    k = cyc + 1;
    @(negedge CLOCK_50_I);
    Start = 1'b0; Start_address = '0; Word_count = '0;
  endtask

  task automatic analyze(input string tag, input int k, input logic [17:0] a0, input int nb,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bs [4];
    logic [9:0] fr;
    logic [7:0] dec;
    int errs, s, end_i, dcount, highs_bad;
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    errs = 0;
    check({tag, "_line_before_fall"}, line_log[k+3], 1'b1);
    check({tag, "_line_fall"}, line_log[k+4], 1'b0);
    check({tag, "_addr"}, addr_log[k], a0);
    for (int f = 0; f < nb; f++) begin
      s  = k + 4 + FRAME * f;
      fr = {1'b1, bs[f], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < CPB; c++)
          if (line_log[s + CPB * b + c] !== fr[b]) errs++;
      for (int b = 1; b <= 8; b++) dec[b-1] = line_log[s + CPB * b + CPB / 2];
      check($sformatf("%s_byte%0d", tag, f), dec, bs[f]);
    end
    check({tag, "_bitcell_errors"}, errs, 0);
    end_i = k + 4 + FRAME * nb;
    highs_bad = 0;
    for (int i = end_i; i < end_i + 10; i++) if (line_log[i] !== 1'b1) highs_bad++;
    check({tag, "_line_idle_after"}, highs_bad, 0);
    dcount = 0;
    for (int i = k - 1; i < end_i + 20; i++) if (done_log[i] === 1'b1) dcount++;
    check({tag, "_done_count"}, dcount, 1);
    check({tag, "_done_time"}, done_log[end_i+1], 1'b1);
    check({tag, "_busy_before"}, busy_log[k-1], 1'b0);
    check({tag, "_busy_start"}, busy_log[k], 1'b1);
    check({tag, "_busy_last"}, busy_log[end_i], 1'b1);
    check({tag, "_busy_drop"}, busy_log[end_i+1], 1'b0);
  endtask

  initial begin
    int k, k2, bad_line, bad_busy, bad_done, bad_we;
    resetn = 1'b0; Start = 1'b0; Start_address = '0; Word_count = '0;
    repeat (3) @(negedge CLOCK_50_I);
    check("rst_line", UART_TX_O, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_addr", SRAM_address, 18'h0);
    resetn = 1'b1;

    // Idle with no Start.
    bad_line = 0; bad_busy = 0; bad_done = 0; bad_we = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLOCK_50_I);
      if (UART_TX_O !== 1'b1) bad_line++;
      if (Busy !== 1'b0) bad_busy++;
      if (Done !== 1'b0) bad_done++;
      if (SRAM_we_n !== 1'b1) bad_we++;
    end
    check("idle_line_low_cycles", bad_line, 0);
    check("idle_busy_cycles", bad_busy, 0);
    check("idle_done_cycles", bad_done, 0);
    check("idle_we_n_low_cycles", bad_we, 0);

    // One word.
    start_xfer(18'h00010, 18'd1, k);
    wait_until(k + 4 + 2 * FRAME + 30);
    analyze("one_word", k, 18'h00010, 2, 8'hA5, 8'h5A, 8'h00, 8'h00);

    // Two words across the address wrap.
    start_xfer(18'h3FFFF, 18'd2, k);
    wait_until(k + 4 + 4 * FRAME + 30);
    analyze("wrap", k, 18'h3FFFF, 4, 8'h12, 8'h34, 8'hBE, 8'hEF);
    check("wrap_addr_first", addr_log[k+43], 18'h3FFFF);
    check("wrap_addr_prefetch", addr_log[k+44], 18'h00000);

    // Zero-length transfer.
    start_xfer(18'h00100, 18'd0, k);
    wait_until(k + 30);
    check("zero_done_before", done_log[k-1], 1'b0);
    check("zero_done_pulse", done_log[k], 1'b1);
    check("zero_done_after", done_log[k+1], 1'b0);
    bad_line = 0; bad_busy = 0;
    for (int i = k - 1; i < k + 25; i++) begin
      if (line_log[i] !== 1'b1) bad_line++;
      if (busy_log[i] !== 1'b0) bad_busy++;
    end
    check("zero_line_low_cycles", bad_line, 0);
    check("zero_busy_cycles", bad_busy, 0);
    check("zero_addr_held", addr_log[k+2], 18'h00000);

    // Start while busy is ignored.
    start_xfer(18'h00010, 18'd1, k);
    wait_until(k + 20);
    start_xfer(18'h3FFFF, 18'd2, k2);
    wait_until(k + 4 + 2 * FRAME + 30);
    analyze("ignore", k, 18'h00010, 2, 8'hA5, 8'h5A, 8'h00, 8'h00);
    check("ignore_addr_held", addr_log[k+60], 18'h00010);

    // Reset during data bit 0 of the second byte (0x34, bit 0 is low).
    start_xfer(18'h3FFFF, 18'd2, k);
    wait_until(k + 49);
    check("rst_mid_line_before", UART_TX_O, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst_mid_line", UART_TX_O, 1'b1);
    check("rst_mid_busy", Busy, 1'b0);
    check("rst_mid_done", Done, 1'b0);
    repeat (3) @(negedge CLOCK_50_I);
    resetn = 1'b1;
    start_xfer(18'h00010, 18'd1, k);
    wait_until(k + 4 + 2 * FRAME + 30);
    analyze("post_rst", k, 18'h00010, 2, 8'hA5, 8'h5A, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
